// File: rtl/fadd_pipe.sv
// rtl/fadd_pipe.sv - three-stage pipelined IEEE-754 adder/subtractor with valid/ready handshake
module fadd_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  localparam int W = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic [1:0]   rm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         ovf,
  output logic         inx,
  output logic         inv,
  output logic [2:0]   flags,
  input  logic         flag_clr
);

  // M: hidden bit + fraction + guard/round/sticky; XE: exponent with overflow headroom
  localparam int M  = FRAC_W + 4;
  localparam int XE = EXP_W + 2;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  logic adv;
  logic v0, v1, v2;

  // operand capture stage
  logic [W-1:0] p0_a, p0_b;
  logic         p0_sub;
  logic [1:0]   p0_rm;

  // align stage outputs
  logic [EXP_W-1:0]  ea, eb, xa, xb, xl, xs, ediff;
  logic [FRAC_W-1:0] fa, fb;
  logic              sa, sbe, sl, swap;
  logic              nan_a, nan_b, inf_a, inf_b;
  logic [M-1:0]      ma, mb, ml, ms, ms_al;
  logic [2*M-1:0]    shw;
  logic              sp_c;
  logic [W-1:0]      sp_res_c;
  logic              sp_inv_c;

  logic [EXP_W-1:0] p1_e;
  logic [M-1:0]     p1_ml, p1_ms;
  logic             p1_sign, p1_esub, p1_zs, p1_sp, p1_spinv;
  logic [W-1:0]     p1_spres;
  logic [1:0]       p1_rm;

  logic [M:0]       sum_c;
  logic [M:0]       p2_sum;
  logic [EXP_W-1:0] p2_e;
  logic             p2_sign, p2_zs, p2_sp, p2_spinv;
  logic [W-1:0]     p2_spres;
  logic [1:0]       p2_rm;

  // normalise/round stage
  int                lz, lim, shamt;
  logic [M-1:0]      mn;
  logic [XE-1:0]     en, ef;
  logic              g, r, st, lsb, any, up, to_inf, ovf_c;
  logic [FRAC_W+1:0] rnd;
  logic [FRAC_W-1:0] frac;
  logic [W-1:0]      res_c;
  logic              ovf_o, inx_o, inv_o;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    ea    = p0_a[W-2:FRAC_W];
    eb    = p0_b[W-2:FRAC_W];
    fa    = p0_a[FRAC_W-1:0];
    fb    = p0_b[FRAC_W-1:0];
    sa    = p0_a[W-1];
    sbe   = p0_b[W-1] ^ p0_sub;
    nan_a = (&ea) & (|fa);
    nan_b = (&eb) & (|fb);
    inf_a = (&ea) & ~(|fa);
    inf_b = (&eb) & ~(|fb);
    xa    = (ea == '0) ? EXP_W'(1) : ea;
    xb    = (eb == '0) ? EXP_W'(1) : eb;
    ma    = {|ea, fa, 3'b000};
    mb    = {|eb, fb, 3'b000};
    swap  = {eb, fb} > {ea, fa};
    sl    = swap ? sbe : sa;
    xl    = swap ? xb : xa;
    xs    = swap ? xa : xb;
    ml    = swap ? mb : ma;
    ms    = swap ? ma : mb;
    ediff = xl - xs;
    shw   = {ms, {M{1'b0}}} >> ediff;
    if (32'(ediff) >= FRAC_W + 3) ms_al = {{(M-1){1'b0}}, |ms};
    else ms_al = shw[2*M-1:M] | {{(M-1){1'b0}}, |shw[M-1:0]};

    sp_c     = nan_a | nan_b | inf_a | inf_b;
    sp_res_c = QNAN;
    sp_inv_c = 1'b0;
    if (nan_a | nan_b) begin
      sp_inv_c = (nan_a & ~fa[FRAC_W-1]) | (nan_b & ~fb[FRAC_W-1]);
    end else if (inf_a & inf_b & (sa != sbe)) begin
      sp_inv_c = 1'b1;
    end else if (inf_a) begin
      sp_res_c = p0_a;
    end else if (inf_b) begin
      sp_res_c = {sbe, p0_b[W-2:0]};
    end
  end

  // magnitudes are pre-ordered, so subtraction never goes negative
  assign sum_c = p1_esub ? ({1'b0, p1_ml} - {1'b0, p1_ms}) : ({1'b0, p1_ml} + {1'b0, p1_ms});

  always_comb begin
    lz = M;
    for (int i = 0; i < M; i++) begin
      if (p2_sum[i]) lz = M - 1 - i;
    end
    lim   = int'(p2_e) - 1;
    shamt = 0;
    if (p2_sum[M]) begin
      mn = p2_sum[M:1] | {{(M-1){1'b0}}, p2_sum[0]};
      en = XE'(p2_e) + XE'(1);
    end else begin
      shamt = (lz < lim) ? lz : lim;
      mn    = p2_sum[M-1:0] << shamt;
      en    = XE'(p2_e) - XE'(shamt);
    end

    g   = mn[2];
    r   = mn[1];
    st  = mn[0];
    lsb = mn[3];
    any = g | r | st;
    case (p2_rm)
      2'd0:    up = g & (r | st | lsb);
      2'd1:    up = p2_sign & any;
      2'd2:    up = ~p2_sign & any;
      default: up = 1'b0;
    endcase
    rnd = {1'b0, mn[M-1:3]} + (FRAC_W+2)'(up);

    // a carry out of rounding bumps the exponent; no hidden bit means denormal
    if (rnd[FRAC_W+1]) begin
      ef   = en + XE'(1);
      frac = '0;
    end else if (rnd[FRAC_W]) begin
      ef   = en;
      frac = rnd[FRAC_W-1:0];
    end else begin
      ef   = '0;
      frac = rnd[FRAC_W-1:0];
    end

    ovf_c  = ef >= XE'({EXP_W{1'b1}});
    to_inf = (p2_rm == 2'd0) | ((p2_rm == 2'd1) & p2_sign) | ((p2_rm == 2'd2) & ~p2_sign);
    res_c  = {p2_sign, ef[EXP_W-1:0], frac};
    ovf_o  = 1'b0;
    inx_o  = any;
    inv_o  = 1'b0;
    if (p2_sp) begin
      res_c = p2_spres;
      inx_o = 1'b0;
      inv_o = p2_spinv;
    end else if (p2_sum == '0) begin
      res_c = {p2_zs, {(W-1){1'b0}}};
      inx_o = 1'b0;
    end else if (ovf_c) begin
      res_c = to_inf ? {p2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                     : {p2_sign, {{(EXP_W-1){1'b1}}, 1'b0}, {FRAC_W{1'b1}}};
      ovf_o = 1'b1;
      inx_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      p0_a     <= a;
      p0_b     <= b;
      p0_sub   <= sub;
      p0_rm    <= rm;
      p1_e     <= xl;
      p1_ml    <= ml;
      p1_ms    <= ms_al;
      p1_sign  <= sl;
      p1_esub  <= sa ^ sbe;
      p1_zs    <= (sa == sbe) ? sa : (p0_rm == 2'd1);
      p1_sp    <= sp_c;
      p1_spres <= sp_res_c;
      p1_spinv <= sp_inv_c;
      p1_rm    <= p0_rm;
      p2_sum   <= sum_c;
      p2_e     <= p1_e;
      p2_sign  <= p1_sign;
      p2_zs    <= p1_zs;
      p2_sp    <= p1_sp;
      p2_spres <= p1_spres;
      p2_spinv <= p1_spinv;
      p2_rm    <= p1_rm;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      s         <= '0;
      ovf       <= 1'b0;
      inx       <= 1'b0;
      inv       <= 1'b0;
    end else if (adv) begin
      v0        <= in_valid;
      v1        <= v0;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        s   <= res_c;
        ovf <= ovf_o;
        inx <= inx_o;
        inv <= inv_o;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      flags <= 3'b000;
    end else if (out_valid && out_ready) begin
      flags <= (flag_clr ? 3'b000 : flags) | {inv, ovf, inx};
    end else if (flag_clr) begin
      flags <= 3'b000;
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// tb/tb_fadd_pipe.sv - directed and randomized checks of fadd_pipe against an exact-arithmetic model
module tb_fadd_pipe;

  typedef struct {
    logic [31:0] s;
    logic [2:0]  f;
    int          acc;
    bit          lat;
  } item_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        sub;
  logic [1:0]  rm;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] s;
  logic        ovf, inx, inv;
  logic [2:0]  flags;
  logic        flag_clr = 1'b0;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    or_mode = 0;
  int    win_lo = 0, win_hi = 0;
  bit    fc_rand = 1'b0;
  bit    saw_stall = 1'b0;
  bit    front_seen = 1'b0;
  logic [2:0] ef = 3'b000;
  item_t q[$];

  fadd_pipe dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .ovf(ovf), .inx(inx), .inv(inv), .flags(flags), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (or_mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = !(cyc >= win_lo && cyc <= win_hi);
      default: out_ready = 1'b1;
    endcase
    flag_clr = fc_rand && ($urandom_range(0, 7) == 0);
  end

  // exact sum in units of the smallest denormal, then IEEE rounding of that integer
  function automatic logic [34:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic sb, input logic [1:0] m);
    logic [299:0] mx, my, mag, kept, rem, half;
    logic sx, sy, sg, up, inexact, nx, ny, ix, iy;
    int ex, ey, p, k, fld;
    sx = x[31];
    sy = y[31] ^ sb;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    if (nx || ny) return {32'h7FC00000, (nx && !x[22]) || (ny && !y[22]), 2'b00};
    if (ix && iy) return (sx != sy) ? {32'h7FC00000, 3'b100} : {x, 3'b000};
    if (ix) return {x, 3'b000};
    if (iy) return {sy, 8'hFF, 23'h0, 3'b000};
    mx = 300'({ex != 0, x[22:0]}) << ((ex == 0) ? 0 : ex - 1);
    my = 300'({ey != 0, y[22:0]}) << ((ey == 0) ? 0 : ey - 1);
    if (sx == sy) begin mag = mx + my; sg = sx; end
    else if (mx >= my) begin mag = mx - my; sg = sx; end
    else begin mag = my - mx; sg = sy; end
    if (mag == 0) return {(sx == sy) ? sx : (m == 2'd1), 31'h0, 3'b000};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    k = (p > 23) ? p - 23 : 0;
    kept = mag >> k;
    rem = mag & ((300'(1) << k) - 300'(1));
    half = (k > 0) ? (300'(1) << (k - 1)) : 300'(0);
    inexact = (rem != 0);
    case (m)
      2'd0:    up = inexact && (rem > half || (rem == half && kept[0]));
      2'd1:    up = inexact && sg;
      2'd2:    up = inexact && !sg;
      default: up = 1'b0;
    endcase
    kept = kept + 300'(up);
    if (kept == (300'(1) << 24)) begin kept = kept >> 1; k++; end
    fld = kept[23] ? k + 1 : 0;
    if (fld >= 255) begin
      if (m == 2'd0 || (m == 2'd1 && sg) || (m == 2'd2 && !sg)) return {sg, 8'hFF, 23'h0, 3'b011};
      return {sg, 8'hFE, 23'h7FFFFF, 3'b011};
    end
    return {sg, 8'(fld), kept[22:0], 2'b00, inexact};
  endfunction

  always @(negedge clk) begin
    item_t it;
    if (!clrn) begin
      ef = 3'b000;
      front_seen = 1'b0;
    end else begin
      checks++;
      assert (in_ready === (out_ready || !out_valid)) else begin
        errors++; $error("FAIL in_ready got %b want %b", in_ready, out_ready || !out_valid);
      end
      checks++;
      assert (flags === ef) else begin
        errors++; $error("FAIL flags got %b want %b", flags, ef);
      end
      if (out_valid && !out_ready) saw_stall = 1'b1;
      if (out_valid) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++; $error("FAIL spurious_out got s=%h want no output", s);
        end
      end
      if (out_valid && q.size() != 0) begin
        if (!front_seen && q[0].lat) begin
          checks++;
          assert (cyc - q[0].acc == 3) else begin
            errors++; $error("FAIL latency got %0d want 3", cyc - q[0].acc);
          end
        end
        front_seen = 1'b1;
      end
      if (out_valid && out_ready && q.size() != 0) begin
        it = q.pop_front();
        checks++;
        assert ({s, inv, ovf, inx} === {it.s, it.f}) else begin
          errors++; $error("FAIL result got s=%h ivx=%b want s=%h ivx=%b", s, {inv, ovf, inx}, it.s, it.f);
        end
        ef = (flag_clr ? 3'b000 : ef) | it.f;
        front_seen = 1'b0;
      end else if (flag_clr) begin
        ef = 3'b000;
      end
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tsub,
                      input logic [1:0] trm, input logic [31:0] es, input logic [2:0] efl, input bit lat);
    item_t it;
    bit acc = 1'b0;
    int n = 0;
    a = ta; b = tb; sub = tsub; rm = trm; in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        it.s = es; it.f = efl; it.acc = cyc + 1; it.lat = lat;
        q.push_back(it);
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    rm = 2'($urandom);
    sub = 1'($urandom);
    checks++;
    assert (acc) else begin errors++; $error("FAIL accept got timeout want accepted"); end
  endtask

  task automatic send_rand(input bit lat);
    logic [31:0] x, y;
    logic sb;
    logic [1:0] m;
    logic [34:0] r;
    x = $urandom; y = $urandom;
    sb = 1'($urandom); m = 2'($urandom);
    case ($urandom_range(0, 7))
      0, 1, 2: y[30:23] = x[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
      3: begin y = x; y[7:0] = 8'($urandom); y[31] = 1'($urandom); sb = ~(x[31] ^ y[31]); end
      4: begin
        x[30:23] = 8'($urandom_range(0, 2)); y[30:23] = 8'($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) begin x[30:0] = 31'h0; y[30:0] = 31'h0; end
      end
      5: begin
        if ($urandom_range(0, 1) != 0) x[30:23] = 8'hFF; else y[30:23] = 8'hFF;
        if ($urandom_range(0, 1) != 0) begin x[22:0] = 23'h0; y[22:0] = 23'h0; end
      end
      6: begin x = {x[31], 8'hFF, 23'h0}; y = {y[31], 8'hFF, 23'h0}; end
      default: begin x[30:23] = 8'hFE; y[30:23] = 8'hFE - 8'($urandom_range(0, 2)); end
    endcase
    r = ref_add(x, y, sb, m);
    send(x, y, sb, m, r[34:3], r[2:0], lat);
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (q.size() == 0) else begin errors++; $error("FAIL drain got %0d pending want 0", q.size()); end
  endtask

  initial begin
    clrn = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; rm = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_valid got %b want 0", out_valid); end
    checks++; assert (s === 32'h0) else begin errors++; $error("FAIL rst_s got %h want 0", s); end
    checks++; assert ({inv, ovf, inx} === 3'b000) else begin errors++; $error("FAIL rst_ivx got %b want 000", {inv, ovf, inx}); end
    checks++; assert (flags === 3'b000) else begin errors++; $error("FAIL rst_flags got %b want 000", flags); end
    clrn = 1'b1;
    @(posedge clk);
    #1;

    send(32'h3FC00000, 32'h40100000, 1'b0, 2'd0, 32'h40700000, 3'b000, 1'b1);
    drain();
    send(32'h3F800000, 32'h33800000, 1'b0, 2'd0, 32'h3F800000, 3'b001, 1'b1);
    send(32'h3F800000, 32'h33800000, 1'b0, 2'd2, 32'h3F800001, 3'b001, 1'b1);
    send(32'h3F800000, 32'h33800000, 1'b0, 2'd1, 32'h3F800000, 3'b001, 1'b1);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd0, 32'h7F800000, 3'b011, 1'b1);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd3, 32'h7F7FFFFF, 3'b011, 1'b1);
    send(32'h7F800000, 32'h7F800000, 1'b1, 2'd0, 32'h7FC00000, 3'b100, 1'b1);
    send(32'h40400000, 32'h40400000, 1'b1, 2'd0, 32'h00000000, 3'b000, 1'b1);
    send(32'h40400000, 32'h40400000, 1'b1, 2'd1, 32'h80000000, 3'b000, 1'b1);
    drain();
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;

    or_mode = 2; win_lo = cyc + 4; win_hi = cyc + 8;
    for (int i = 0; i < 5; i++) send_rand(1'b0);
    drain();
    checks++; assert (saw_stall) else begin errors++; $error("FAIL stall got no stall want in_ready low"); end
    or_mode = 0;

    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd0, 32'h7F800000, 3'b011, 1'b1);
    drain();
    send(32'h3FC00000, 32'h40100000, 1'b0, 2'd0, 32'h40700000, 3'b000, 1'b1);
    send(32'h3F800000, 32'h33800000, 1'b0, 2'd2, 32'h3F800001, 3'b001, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; assert (out_valid === 1'b1) else begin errors++; $error("FAIL inflight got %b want 1", out_valid); end
    clrn = 1'b0;
    #1;
    q.delete();
    checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL midrst_valid got %b want 0", out_valid); end
    checks++; assert (flags === 3'b000) else begin errors++; $error("FAIL midrst_flags got %b want 000", flags); end
    @(posedge clk);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    @(posedge clk);
    #1;
    send(32'h40400000, 32'h40400000, 1'b1, 2'd1, 32'h80000000, 3'b000, 1'b1);
    drain();

    or_mode = 1; fc_rand = 1'b1;
    for (int i = 0; i < 300; i++) send_rand(1'b0);
    drain();
    or_mode = 0; fc_rand = 1'b0;
    for (int i = 0; i < 20; i++) send_rand(1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
